// File: rtl/id_exe_stage.sv
// id_exe_stage: ID-to-EXE pipeline stage.
// Selects forwarded operands, registers the ID/EXE pipeline fields, detects
// load-use hazards (one-cycle stall plus bubble), and honours hold/flush.
// Optional macro LU_STALL_CNT_EN adds a saturating stall_count output.
module id_exe_stage #(
  parameter int          DATA_W   = 32,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [31:0]       ID_inst,
  input  logic [31:0]       ID_pc4,
  input  logic [DATA_W-1:0] rf_rdataA,
  input  logic [DATA_W-1:0] rf_rdataB,
  input  logic [1:0]        forwardA,
  input  logic [1:0]        forwardB,
  input  logic [DATA_W-1:0] EXE_result,
  input  logic [DATA_W-1:0] MEM_result,
  input  logic [DATA_W-1:0] WB_result,
  input  logic              EXE_is_load,
  input  logic              hold,
  input  logic              flush,
  output logic [DATA_W-1:0] ID_opA,
  output logic [DATA_W-1:0] ID_opB,
  output logic              stall,
  output logic [31:0]       EXE_inst,
  output logic [31:0]       EXE_pc4,
  output logic [DATA_W-1:0] EXE_opA,
  output logic [DATA_W-1:0] EXE_opB,
  output logic [31:0]       EXE_imm,
  output logic              EXE_valid
`ifdef LU_STALL_CNT_EN
  ,
  output logic [31:0]       stall_count
`endif
);

  typedef enum logic {RUN, LU_STALL} state_e;

  state_e            state_q, state_d;
  logic [31:0]       inst_q, inst_d;
  logic [31:0]       pc4_q, pc4_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [31:0]       imm_q, imm_d;
  logic              valid_q, valid_d;
  logic              lu;

  // Operand source selection: regfile or one of the in-flight results.
  always_comb begin
    unique case (forwardA)
      2'd0:    ID_opA = rf_rdataA;
      2'd1:    ID_opA = EXE_result;
      2'd2:    ID_opA = MEM_result;
      default: ID_opA = WB_result;
    endcase
    unique case (forwardB)
      2'd0:    ID_opB = rf_rdataB;
      2'd1:    ID_opB = EXE_result;
      2'd2:    ID_opB = MEM_result;
      default: ID_opB = WB_result;
    endcase
  end

  // A load in EXE cannot forward its data to ID in the same cycle.
  assign lu    = EXE_is_load && valid_q && (forwardA == 2'd1 || forwardB == 2'd1);
  assign stall = (state_q == RUN) && lu && !hold && !flush;

  // Next-state and pipeline-register update; hold > flush > load-use > capture.
  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    imm_d   = imm_q;
    valid_d = valid_q;
    if (!hold) begin
      if (flush || (state_q == RUN && lu)) begin
        // Bubble: PC+4 still follows ID so the slot keeps a sensible PC.
        inst_d  = NOP_INST;
        pc4_d   = ID_pc4;
        opa_d   = '0;
        opb_d   = '0;
        imm_d   = '0;
        valid_d = 1'b0;
        state_d = flush ? RUN : LU_STALL;
      end else begin
        inst_d  = ID_inst;
        pc4_d   = ID_pc4;
        opa_d   = ID_opA;
        opb_d   = ID_opB;
        imm_d   = {{16{ID_inst[15]}}, ID_inst[15:0]};
        valid_d = 1'b1;
        state_d = RUN;
      end
    end
  end

  // State and ID/EXE pipeline register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= RUN;
      inst_q  <= NOP_INST;
      pc4_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      imm_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      imm_q   <= imm_d;
      valid_q <= valid_d;
    end
  end

  assign EXE_inst  = inst_q;
  assign EXE_pc4   = pc4_q;
  assign EXE_opA   = opa_q;
  assign EXE_opB   = opb_q;
  assign EXE_imm   = imm_q;
  assign EXE_valid = valid_q;

`ifdef LU_STALL_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  // Saturating count of load-use stall cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && cnt_q != '1) cnt_d = cnt_q + 32'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign stall_count = cnt_q;
`endif

endmodule

// File: tb/tb_id_exe_stage.sv
// tb_id_exe_stage: directed self-checking bench for id_exe_stage.
// Define LU_STALL_CNT_EN to also exercise stall_count.
module tb_id_exe_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] ID_inst, ID_pc4;
  logic [31:0] rf_rdataA, rf_rdataB, EXE_result, MEM_result, WB_result;
  logic [1:0]  forwardA, forwardB;
  logic        EXE_is_load, hold, flush;
  logic [31:0] ID_opA, ID_opB;
  logic        stall;
  logic [31:0] EXE_inst, EXE_pc4, EXE_opA, EXE_opB, EXE_imm;
  logic        EXE_valid;
`ifdef LU_STALL_CNT_EN
  logic [31:0] stall_count;
`endif

  int checks = 0;
  int failures = 0;

  id_exe_stage #(.DATA_W(32), .NOP_INST(NOP)) dut (
    .clk(clk), .nrst(nrst), .ID_inst(ID_inst), .ID_pc4(ID_pc4),
    .rf_rdataA(rf_rdataA), .rf_rdataB(rf_rdataB),
    .forwardA(forwardA), .forwardB(forwardB),
    .EXE_result(EXE_result), .MEM_result(MEM_result), .WB_result(WB_result),
    .EXE_is_load(EXE_is_load), .hold(hold), .flush(flush),
    .ID_opA(ID_opA), .ID_opB(ID_opB), .stall(stall),
    .EXE_inst(EXE_inst), .EXE_pc4(EXE_pc4), .EXE_opA(EXE_opA),
    .EXE_opB(EXE_opB), .EXE_imm(EXE_imm), .EXE_valid(EXE_valid)
`ifdef LU_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  // Advance one rising edge; sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    nrst = 1'b0;
    #3;
    nrst = 1'b1;
    tick();
  endtask

  task automatic defaults();
    ID_inst = 32'h0; ID_pc4 = 32'h0;
    rf_rdataA = 32'h1; rf_rdataB = 32'h11;
    EXE_result = 32'h2; MEM_result = 32'h3; WB_result = 32'h4;
    forwardA = 2'd0; forwardB = 2'd0;
    EXE_is_load = 1'b0; hold = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    defaults();
    ID_inst = 32'h0000_1234; ID_pc4 = 32'h104; forwardA = 2'd3; forwardB = 2'd1;
    tick();
    checks++; if (EXE_valid !== 1'b1) begin failures++; $display("FAIL pre_reset_valid got=%0b exp=1", EXE_valid); end
    #2 nrst = 1'b0;
    #1;
    checks++; if (EXE_inst !== NOP) begin failures++; $display("FAIL reset_inst got=%h exp=%h", EXE_inst, NOP); end
    checks++; if ({EXE_pc4, EXE_opA, EXE_opB, EXE_imm} !== 128'h0) begin failures++; $display("FAIL reset_fields got=%h exp=0", {EXE_pc4, EXE_opA, EXE_opB, EXE_imm}); end
    checks++; if (EXE_valid !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL reset_valid_stall got=%b%b exp=00", EXE_valid, stall); end
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_forward();
    logic [31:0] exp_a [4];
    exp_a[0] = 32'h1; exp_a[1] = 32'h2; exp_a[2] = 32'h3; exp_a[3] = 32'h4;
    defaults();
    for (int i = 0; i < 4; i++) begin
      forwardA = 2'(i); forwardB = 2'(3 - i);
      ID_pc4 = 32'h200 + 32'(i * 4);
      #1;
      checks++; if (ID_opA !== exp_a[i]) begin failures++; $display("FAIL fwdA_%0d got=%h exp=%h", i, ID_opA, exp_a[i]); end
      checks++; if (ID_opB !== ((i == 3) ? 32'h11 : exp_a[3 - i])) begin failures++; $display("FAIL fwdB_%0d got=%h", i, ID_opB); end
      tick();
      checks++; if (EXE_opA !== exp_a[i] || EXE_pc4 !== 32'h200 + 32'(i * 4)) begin failures++; $display("FAIL exe_opA_%0d got=%h pc4=%h exp=%h", i, EXE_opA, EXE_pc4, exp_a[i]); end
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    defaults();
    ID_inst = 32'h8C43_0000; EXE_is_load = 1'b0;
    tick();                                 // load now in EXE, valid
    EXE_is_load = 1'b1; forwardA = 2'd0; forwardB = 2'd0;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL fwd0_no_hazard got=%b exp=0", stall); end
    ID_inst = 32'h0043_2020; ID_pc4 = 32'h308; forwardA = 2'd1;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", stall); end
    tick();
    checks++; if (EXE_valid !== 1'b0 || EXE_inst !== NOP || EXE_opA !== 32'h0 || EXE_pc4 !== 32'h308) begin failures++; $display("FAIL lu_bubble got v=%b inst=%h opA=%h pc4=%h", EXE_valid, EXE_inst, EXE_opA, EXE_pc4); end
    forwardA = 2'd2; MEM_result = 32'h55;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lu_second_cycle got=%b exp=0", stall); end
    tick();
    checks++; if (EXE_opA !== 32'h55 || EXE_inst !== 32'h0043_2020 || EXE_valid !== 1'b1) begin failures++; $display("FAIL lu_capture got opA=%h inst=%h v=%b", EXE_opA, EXE_inst, EXE_valid); end
    // hazard on operand B alone
    forwardA = 2'd0; forwardB = 2'd1;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lu_stall_B got=%b exp=1", stall); end
    tick();
  endtask

  task automatic test_flush();
    apply_reset();
    defaults();
    tick();
    EXE_is_load = 1'b1; forwardA = 2'd1; flush = 1'b1; ID_pc4 = 32'h400;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", stall); end
    tick();
    checks++; if (EXE_valid !== 1'b0 || EXE_inst !== NOP || EXE_pc4 !== 32'h400) begin failures++; $display("FAIL flush_bubble got v=%b inst=%h pc4=%h", EXE_valid, EXE_inst, EXE_pc4); end
    // still in RUN: next normal instruction captures and a new hazard stalls
    flush = 1'b0; forwardA = 2'd0; ID_inst = 32'hAB;
    tick();
    forwardA = 2'd1;
    #1;
    checks++; if (EXE_inst !== 32'hAB || stall !== 1'b1) begin failures++; $display("FAIL flush_run got inst=%h stall=%b", EXE_inst, stall); end
  endtask

  task automatic test_hold();
    apply_reset();
    defaults();
    tick();
    EXE_is_load = 1'b1; forwardA = 2'd1; hold = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL hold_masks_stall got=%b exp=0", stall); end
    hold = 1'b0; ID_pc4 = 32'h500;
    tick();                                 // bubble, now in LU_STALL
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ID_inst = 32'h1000 + 32'(i); ID_pc4 = 32'h600 + 32'(i); forwardA = 2'd3;
      tick();
      checks++; if (EXE_inst !== NOP || EXE_pc4 !== 32'h500 || EXE_valid !== 1'b0 || EXE_opA !== 32'h0) begin failures++; $display("FAIL hold_%0d got inst=%h pc4=%h v=%b", i, EXE_inst, EXE_pc4, EXE_valid); end
    end
    hold = 1'b0; ID_inst = 32'h0043_2020; ID_pc4 = 32'h504; forwardA = 2'd2; MEM_result = 32'h77;
    tick();
    checks++; if (EXE_inst !== 32'h0043_2020 || EXE_opA !== 32'h77 || EXE_pc4 !== 32'h504 || EXE_valid !== 1'b1) begin failures++; $display("FAIL hold_release got inst=%h opA=%h v=%b", EXE_inst, EXE_opA, EXE_valid); end
  endtask

  task automatic test_imm();
    defaults();
    ID_inst = 32'h2000_FFFC;
    tick();
    checks++; if (EXE_imm !== 32'hFFFF_FFFC) begin failures++; $display("FAIL imm_neg got=%h exp=FFFFFFFC", EXE_imm); end
    ID_inst = 32'hFFFF_7FFF;
    tick();
    checks++; if (EXE_imm !== 32'h0000_7FFF) begin failures++; $display("FAIL imm_pos got=%h exp=00007FFF", EXE_imm); end
  endtask

`ifdef LU_STALL_CNT_EN
  task automatic test_counter();
    apply_reset();
    defaults();
    checks++; if (stall_count !== 32'h0) begin failures++; $display("FAIL cnt_reset got=%0d exp=0", stall_count); end
    for (int n = 0; n < 2; n++) begin
      EXE_is_load = 1'b0; forwardA = 2'd0;
      tick();                               // valid load in EXE
      EXE_is_load = 1'b1; forwardA = 2'd1; hold = 1'b1;
      tick();                               // held: not counted
      hold = 1'b0;
      tick();                               // stall cycle
      forwardA = 2'd2;
      tick();
    end
    checks++; if (stall_count !== 32'd2) begin failures++; $display("FAIL cnt_two got=%0d exp=2", stall_count); end
  endtask
`endif

  initial begin
    defaults();
    nrst = 1'b0;
    #12 nrst = 1'b1;
    tick();
    test_reset();
    test_forward();
    test_load_use();
    test_flush();
    test_hold();
    test_imm();
`ifdef LU_STALL_CNT_EN
    test_counter();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_exe_stage.md
Name: id_exe_stage

Overview:
- ID-to-EXE pipeline stage that consumes the 2-bit forwardA/forwardB operand-source codes produced in ID.
- Selects each operand from the register file or the EXE/MEM/WB results, and registers the operands, sign-extended immediate and instruction into the ID/EXE pipeline register.
- Detects load-use hazards the forwarding path cannot cover, stalls IF/ID for one cycle and injects a bubble.
- Honours a global hold and a control-flow flush.

Parameters:
- DATA_W, 32, operand/result width.
- NOP_INST, 32'h0000_0000, instruction word written into the EXE slot on a bubble.

Ports:
- clk  in  1  clock; rising edge.
- nrst  in  1  asynchronous active-low reset.
- ID_inst  in  32  instruction currently in ID.
- ID_pc4  in  32  PC+4 of ID instruction.
- rf_rdataA  in  DATA_W  register-file read of rs.
- rf_rdataB  in  DATA_W  register-file read of rt.
- forwardA  in  2  0=regfile, 1=EXE, 2=MEM, 3=WB.
- forwardB  in  2  same encoding as forwardA, for operand B.
- EXE_result  in  DATA_W  ALU result of the instruction now in EXE.
- MEM_result  in  DATA_W  result of the instruction now in MEM (load data already muxed in).
- WB_result  in  DATA_W  writeback data.
- EXE_is_load  in  1  instruction in EXE is LW.
- hold  in  1  global freeze (memory wait).
- flush  in  1  squash the ID instruction (taken branch/jump).
- ID_opA  out  DATA_W  forwarded operand A (combinational, used by ID branch compare).
- ID_opB  out  DATA_W  forwarded operand B (combinational).
- stall  out  1  freeze PC and IF/ID this cycle.
- EXE_inst  out  32  registered instruction.
- EXE_pc4  out  32  registered PC+4.
- EXE_opA  out  DATA_W  registered operand A.
- EXE_opB  out  DATA_W  registered operand B.
- EXE_imm  out  32  registered sign-extended ID_inst[15:0].
- EXE_valid  out  1  EXE slot holds a real instruction.

Behaviour:
- Operand mux (combinational):
  - ID_opA = forwardA 0/1/2/3 -> rf_rdataA / EXE_result / MEM_result / WB_result; ID_opB likewise with forwardB.
- Load-use condition: lu = EXE_is_load && EXE_valid && (forwardA==1 || forwardB==1).
- State machine, 2 states, RUN and LU_STALL, reset to RUN:
  - RUN:
    - hold=1 -> stay; nothing updates.
    - else flush=1 -> capture bubble, stay RUN.
    - else lu=1 -> stall=1, capture bubble, go LU_STALL.
    - else capture ID fields, stay RUN.
  - LU_STALL:
    - stall=0; the load is now in MEM, so the forwarding code is 2.
    - hold=1 -> stay; nothing updates.
    - else flush=1 -> capture bubble, go RUN.
    - else capture ID fields, go RUN.
    - No second consecutive stall for the same instruction.
- stall = (state==RUN) && lu && !hold && !flush, combinational.
- Capture means, on the rising edge:
  - EXE_inst<=ID_inst, EXE_pc4<=ID_pc4, EXE_opA<=ID_opA, EXE_opB<=ID_opB, EXE_imm<={{16{ID_inst[15]}},ID_inst[15:0]}, EXE_valid<=1.
- Bubble means:
  - EXE_inst<=NOP_INST, EXE_valid<=0, EXE_opA/opB/imm<=0, EXE_pc4<=ID_pc4.
- Latency: one cycle from ID to the EXE outputs; operand selection adds no cycle.
- Priority: hold > flush > load-use > normal.
- Simultaneous flush and lu: flush wins, stall=0, because the squashed instruction needs no operands.
- Reset (nrst low, asynchronous):
  - state=RUN.
  - All EXE_* outputs 0, EXE_inst=NOP_INST, EXE_valid=0.
  - stall=0.
- Reset mid-stall returns to RUN and discards the bubble context.
- forwardA/B==0 is never treated as a hazard, regardless of EXE_is_load.

Optional Feature:
- Macro: LU_STALL_CNT_EN.
- Defined:
  - Adds output stall_count [31:0], reset to 0.
  - Increments on every cycle in which stall=1; does not count held cycles.
  - Saturates at 32'hFFFF_FFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: nrst=0 mid-run with EXE_valid=1 -> all EXE_* outputs 0 immediately, EXE_valid=0, stall=0, state RUN.
- Forward select: rf_rdataA=1, EXE=2, MEM=3, WB=4; forwardA stepped 0..3 -> ID_opA = 1,2,3,4; registered EXE_opA matches one cycle later.
- Load-use on A:
  - Stimulus: EXE_is_load=1, EXE_valid=1, forwardA=1, ID_inst=32'h00432020.
  - Cycle 1: stall=1, EXE_valid=0 on the next edge.
  - Cycle 2: forwardA=2, MEM_result=32'h55 -> stall=0; after the edge EXE_opA=32'h55, EXE_inst=32'h00432020.
- Flush priority: lu condition true and flush=1 -> stall=0, bubble captured, state stays RUN.
- Hold: hold=1 for 3 cycles in LU_STALL with ID inputs changing -> all EXE_* outputs unchanged and state unchanged; release -> capture proceeds.
- Immediate/counter:
  - ID_inst[15:0]=16'hFFFC -> EXE_imm=32'hFFFF_FFFC.
  - With LU_STALL_CNT_EN, two separate load-use stalls -> stall_count=2.
